// File: rtl/reorder_buffer.sv
// Reorder buffer: allocates rename tags in program order, captures CDB results,
// commits the head entry in order and raises a one-cycle flush on a mispredict.
module reorder_buffer #(
  parameter int unsigned ROB_WIDTH = 4
) (
  input  logic                 clockIn,
  input  logic                 resetIn,
  input  logic                 readyIn,
  input  logic                 issueValid,
  input  logic [1:0]           issueKind,
  input  logic [4:0]           issueRd,
  input  logic [31:0]          issuePredPc,
  output logic                 robFull,
  output logic [ROB_WIDTH-1:0] robTail,
  input  logic                 cdbValid,
  input  logic [ROB_WIDTH-1:0] cdbRobId,
  input  logic [31:0]          cdbValue,
  input  logic [31:0]          cdbNextPc,
  input  logic [ROB_WIDTH-1:0] query1Id,
  output logic                 query1Ready,
  output logic [31:0]          query1Value,
  input  logic [ROB_WIDTH-1:0] query2Id,
  output logic                 query2Ready,
  output logic [31:0]          query2Value,
  output logic                 writeFlag,
  output logic [ROB_WIDTH-1:0] robId,
  output logic [4:0]           writeAddr,
  output logic [31:0]          writeValue,
  output logic                 storeCommit,
  output logic [ROB_WIDTH-1:0] storeRobId,
  output logic                 clearOut,
  output logic [31:0]          redirectPc
);

  localparam int unsigned DEPTH = 2 ** ROB_WIDTH;
  localparam int unsigned CW    = ROB_WIDTH + 1;

  localparam logic [1:0] KIND_REG    = 2'd0;
  localparam logic [1:0] KIND_BRANCH = 2'd1;
  localparam logic [1:0] KIND_STORE  = 2'd2;
  localparam logic [1:0] KIND_JUMP   = 2'd3;

  typedef enum logic {RUN, FLUSH} state_t;

  state_t state, stateNext;

  logic [DEPTH-1:0]     validQ, readyQ;
  logic [1:0]           kindQ   [DEPTH];
  logic [4:0]           rdQ     [DEPTH];
  logic [31:0]          valueQ  [DEPTH];
  logic [31:0]          predPcQ [DEPTH];
  logic [31:0]          nextPcQ [DEPTH];
  logic [ROB_WIDTH-1:0] head, tail;
  logic [CW-1:0]        count;

  logic       doIssue, doCdb, doCommit, mispredict, flushDone;
  logic [1:0] headKind;
  logic       hit1, hit2;

  assign headKind = kindQ[head];
  assign robTail  = tail;

  // Next-state and per-cycle control decisions.
  always_comb begin
    stateNext  = state;
    robFull    = 1'b1;
    doIssue    = 1'b0;
    doCdb      = 1'b0;
    doCommit   = 1'b0;
    mispredict = 1'b0;
    flushDone  = 1'b0;
    case (state)
      RUN: begin
        robFull    = (count == CW'(DEPTH));
        doIssue    = issueValid & ~robFull & readyIn;
        doCdb      = cdbValid & readyIn & validQ[cdbRobId];
        doCommit   = validQ[head] & readyQ[head] & readyIn;
        mispredict = doCommit & ((headKind == KIND_BRANCH) | (headKind == KIND_JUMP))
                     & (nextPcQ[head] != predPcQ[head]);
        if (mispredict) stateNext = FLUSH;
      end
      FLUSH: begin
        flushDone = readyIn;
        if (readyIn) stateNext = RUN;
      end
      default: stateNext = RUN;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clockIn or negedge resetIn) begin
    if (!resetIn) state <= RUN;
    else          state <= stateNext;
  end

  // Pointers, occupancy, entry status bits and flush/redirect registers.
  always_ff @(posedge clockIn or negedge resetIn) begin
    if (!resetIn) begin
      head       <= '0;
      tail       <= '0;
      count      <= '0;
      validQ     <= '0;
      readyQ     <= '0;
      clearOut   <= 1'b0;
      redirectPc <= '0;
    end else if (flushDone) begin
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      validQ   <= '0;
      clearOut <= 1'b0;
    end else if (state == RUN) begin
      if (doIssue) begin
        validQ[tail] <= 1'b1;
        readyQ[tail] <= 1'b0;
        tail         <= tail + ROB_WIDTH'(1);
      end
      if (doCdb) readyQ[cdbRobId] <= 1'b1;
      if (doCommit) begin
        validQ[head] <= 1'b0;
        head         <= head + ROB_WIDTH'(1);
      end
      count <= count + CW'(doIssue) - CW'(doCommit);
      if (mispredict) begin
        clearOut   <= 1'b1;
        redirectPc <= nextPcQ[head];
      end
    end
  end

  // Entry payload; gated by the valid bits, so it needs no reset.
  always_ff @(posedge clockIn) begin
    if (doIssue) begin
      kindQ[tail]   <= issueKind;
      rdQ[tail]     <= issueRd;
      predPcQ[tail] <= issuePredPc;
    end
    if (doCdb) begin
      valueQ[cdbRobId]  <= cdbValue;
      nextPcQ[cdbRobId] <= cdbNextPc;
    end
  end

  // Commit port driven straight from the head entry.
  always_comb begin
    writeFlag   = doCommit & ((headKind == KIND_REG) | (headKind == KIND_JUMP));
    robId       = writeFlag ? head : '0;
    writeAddr   = writeFlag ? rdQ[head] : '0;
    writeValue  = writeFlag ? valueQ[head] : '0;
    storeCommit = doCommit & (headKind == KIND_STORE);
    storeRobId  = storeCommit ? head : '0;
  end

  // Operand lookups with same-cycle CDB bypass.
  always_comb begin
    hit1        = cdbValid & (cdbRobId == query1Id);
    hit2        = cdbValid & (cdbRobId == query2Id);
    query1Ready = validQ[query1Id] & (readyQ[query1Id] | hit1);
    query2Ready = validQ[query2Id] & (readyQ[query2Id] | hit2);
    query1Value = '0;
    query2Value = '0;
    if (validQ[query1Id]) query1Value = hit1 ? cdbValue : valueQ[query1Id];
    if (validQ[query2Id]) query2Value = hit2 ? cdbValue : valueQ[query2Id];
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// Bench for reorder_buffer: directed stimulus feeds an expected-event queue that
// a negedge monitor drains as commits, store releases and flushes appear.
module tb_reorder_buffer;

  logic        clockIn = 1'b0;
  logic        resetIn, readyIn;
  logic        issueValid;
  logic [1:0]  issueKind;
  logic [4:0]  issueRd;
  logic [31:0] issuePredPc;
  logic        robFull;
  logic [3:0]  robTail;
  logic        cdbValid;
  logic [3:0]  cdbRobId;
  logic [31:0] cdbValue, cdbNextPc;
  logic [3:0]  query1Id, query2Id;
  logic        query1Ready, query2Ready;
  logic [31:0] query1Value, query2Value;
  logic        writeFlag, storeCommit, clearOut;
  logic [3:0]  robId, storeRobId;
  logic [4:0]  writeAddr;
  logic [31:0] writeValue, redirectPc;

  typedef struct {
    int          typ;   // 0 register write, 1 store release, 2 flush
    logic [3:0]  id;
    logic [4:0]  addr;
    logic [31:0] val;
  } ev_t;

  ev_t sb[$];
  int  total = 0;
  int  bad   = 0;

  reorder_buffer #(.ROB_WIDTH(4)) dut (
    .clockIn(clockIn), .resetIn(resetIn), .readyIn(readyIn),
    .issueValid(issueValid), .issueKind(issueKind), .issueRd(issueRd),
    .issuePredPc(issuePredPc), .robFull(robFull), .robTail(robTail),
    .cdbValid(cdbValid), .cdbRobId(cdbRobId), .cdbValue(cdbValue), .cdbNextPc(cdbNextPc),
    .query1Id(query1Id), .query1Ready(query1Ready), .query1Value(query1Value),
    .query2Id(query2Id), .query2Ready(query2Ready), .query2Value(query2Value),
    .writeFlag(writeFlag), .robId(robId), .writeAddr(writeAddr), .writeValue(writeValue),
    .storeCommit(storeCommit), .storeRobId(storeRobId),
    .clearOut(clearOut), .redirectPc(redirectPc)
  );

  always #5 clockIn = ~clockIn;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  task automatic tick();
    @(posedge clockIn);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic expect_ev(input int typ, input logic [3:0] id, input logic [4:0] addr,
                           input logic [31:0] val);
    ev_t e;
    e.typ = typ; e.id = id; e.addr = addr; e.val = val;
    sb.push_back(e);
  endtask

  task automatic mon_check(input int typ, input logic [3:0] id, input logic [4:0] addr,
                           input logic [31:0] val);
    ev_t e;
    total++;
    if (sb.size() == 0) begin
      bad++;
      $display("FAIL unexpected_event: type=%0d id=%0d addr=%0d val=0x%0h", typ, id, addr, val);
    end else begin
      e = sb.pop_front();
      if (e.typ != typ || e.id !== id || e.addr !== addr || e.val !== val) begin
        bad++;
        $display("FAIL event: got type=%0d id=%0d addr=%0d val=0x%0h expected type=%0d id=%0d addr=%0d val=0x%0h",
                 typ, id, addr, val, e.typ, e.id, e.addr, e.val);
      end
    end
  endtask

  // Monitor: compare every output event against the front of the expected queue.
  initial begin
    logic prevClr;
    prevClr = 1'b0;
    forever begin
      @(negedge clockIn);
      if (resetIn) begin
        if (writeFlag)           mon_check(0, robId, writeAddr, writeValue);
        if (storeCommit)         mon_check(1, storeRobId, 5'd0, 32'd0);
        if (clearOut && !prevClr) mon_check(2, 4'd0, 5'd0, redirectPc);
      end
      prevClr = clearOut;
    end
  end

  task automatic do_reset();
    resetIn = 1'b0;
    tick();
    tick();
    resetIn = 1'b1;
  endtask

  task automatic do_issue(input logic [1:0] kind, input logic [4:0] rd, input logic [31:0] pred);
    issueValid = 1'b1; issueKind = kind; issueRd = rd; issuePredPc = pred;
    tick();
    issueValid = 1'b0;
  endtask

  task automatic do_cdb(input logic [3:0] id, input logic [31:0] val, input logic [31:0] npc);
    cdbValid = 1'b1; cdbRobId = id; cdbValue = val; cdbNextPc = npc;
    tick();
    cdbValid = 1'b0;
  endtask

  initial begin
    resetIn = 1'b0; readyIn = 1'b1;
    issueValid = 1'b0; issueKind = 2'd0; issueRd = 5'd0; issuePredPc = 32'd0;
    cdbValid = 1'b0; cdbRobId = 4'd0; cdbValue = 32'd0; cdbNextPc = 32'd0;
    query1Id = 4'd0; query2Id = 4'd0;

    // Reset state
    tick();
    tick();
    chk("rst_full", 32'(robFull), 32'd0);
    chk("rst_tail", 32'(robTail), 32'd0);
    chk("rst_write", 32'(writeFlag), 32'd0);
    chk("rst_clear", 32'(clearOut), 32'd0);
    chk("rst_redirect", redirectPc, 32'd0);
    chk("rst_query", 32'(query1Ready), 32'd0);
    resetIn = 1'b1;

    // Single REG round trip
    do_issue(2'd0, 5'd5, 32'd0);
    expect_ev(0, 4'd0, 5'd5, 32'h1234);
    do_cdb(4'd0, 32'h1234, 32'd0);
    tick();
    chk("t1_count", 32'(dut.count), 32'd0);
    chk("t1_tail", 32'(robTail), 32'd1);
    chk("t1_idle_write", 32'(writeFlag), 32'd0);

    // Fill to capacity, overflow ignored, wrap after one commit
    do_reset();
    for (int i = 0; i < 16; i++) do_issue(2'd0, 5'(i + 1), 32'd0);
    chk("t2_full", 32'(robFull), 32'd1);
    chk("t2_tail", 32'(robTail), 32'd0);
    do_issue(2'd0, 5'd31, 32'd0);
    chk("t2_ovf_tail", 32'(robTail), 32'd0);
    chk("t2_ovf_count", 32'(dut.count), 32'd16);
    expect_ev(0, 4'd0, 5'd1, 32'h0A0);
    do_cdb(4'd0, 32'h0A0, 32'd0);
    chk("t2_commit_still_full", 32'(robFull), 32'd1);
    issueValid = 1'b1; issueKind = 2'd0; issueRd = 5'd20;
    tick();
    chk("t2_freed_full", 32'(robFull), 32'd0);
    chk("t2_freed_tail", 32'(robTail), 32'd0);
    tick();
    issueValid = 1'b0;
    chk("t2_wrap_tail", 32'(robTail), 32'd1);
    chk("t2_wrap_full", 32'(robFull), 32'd1);

    // Out-of-order completion, in-order commit
    do_reset();
    do_issue(2'd0, 5'd7, 32'd0);
    do_issue(2'd2, 5'd0, 32'd0);
    do_cdb(4'd1, 32'h99, 32'd0);
    expect_ev(0, 4'd0, 5'd7, 32'h55);
    expect_ev(1, 4'd1, 5'd0, 32'd0);
    do_cdb(4'd0, 32'h55, 32'd0);
    tick();
    tick();

    // JUMP mispredict: write, then flush with redirect
    do_issue(2'd3, 5'd1, 32'h100);
    expect_ev(0, 4'd2, 5'd1, 32'h44);
    expect_ev(2, 4'd0, 5'd0, 32'h200);
    do_cdb(4'd2, 32'h44, 32'h200);
    tick();
    chk("t4_clear", 32'(clearOut), 32'd1);
    chk("t4_redirect", redirectPc, 32'h200);
    chk("t4_full", 32'(robFull), 32'd1);
    tick();
    chk("t4_clear_done", 32'(clearOut), 32'd0);
    chk("t4_tail", 32'(robTail), 32'd0);
    chk("t4_empty_full", 32'(robFull), 32'd0);

    // Queries with CDB bypass
    for (int i = 0; i < 4; i++) do_issue(2'd0, 5'(i + 1), 32'd0);
    query1Id = 4'd3; query2Id = 4'd5;
    cdbValid = 1'b1; cdbRobId = 4'd3; cdbValue = 32'd7; cdbNextPc = 32'd0;
    #1;
    chk("t5_bypass_ready", 32'(query1Ready), 32'd1);
    chk("t5_bypass_value", query1Value, 32'd7);
    chk("t5_invalid_ready", 32'(query2Ready), 32'd0);
    chk("t5_invalid_value", query2Value, 32'd0);
    tick();
    cdbValid = 1'b0;
    query2Id = 4'd2;
    #1;
    chk("t5_stored_ready", 32'(query1Ready), 32'd1);
    chk("t5_stored_value", query1Value, 32'd7);
    chk("t5_pending_ready", 32'(query2Ready), 32'd0);

    // readyIn=0 freezes commit and issue
    do_cdb(4'd0, 32'h10, 32'd0);
    readyIn = 1'b0;
    issueValid = 1'b1; issueKind = 2'd0; issueRd = 5'd9;
    #1;
    chk("t6_frozen_write", 32'(writeFlag), 32'd0);
    tick();
    tick();
    chk("t6_frozen_tail", 32'(robTail), 32'd4);
    chk("t6_frozen_count", 32'(dut.count), 32'd4);
    issueValid = 1'b0;
    expect_ev(0, 4'd0, 5'd1, 32'h10);
    readyIn = 1'b1;
    tick();
    chk("t6_resumed_count", 32'(dut.count), 32'd3);

    // Branch mispredict, FLUSH held by readyIn=0, then async reset
    do_reset();
    do_issue(2'd1, 5'd0, 32'h300);
    expect_ev(2, 4'd0, 5'd0, 32'h304);
    do_cdb(4'd0, 32'd0, 32'h304);
    chk("t7_branch_nowrite", 32'(writeFlag), 32'd0);
    tick();
    readyIn = 1'b0;
    tick();
    chk("t7_flush_hold", 32'(clearOut), 32'd1);
    chk("t7_flush_full", 32'(robFull), 32'd1);
    resetIn = 1'b0;
    #1;
    chk("t7_rst_clear", 32'(clearOut), 32'd0);
    chk("t7_rst_count", 32'(dut.count), 32'd0);
    chk("t7_rst_full", 32'(robFull), 32'd0);
    tick();
    resetIn = 1'b1;
    readyIn = 1'b1;
    tick();
    tick();

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/reorder_buffer.md
Name: reorder_buffer

Overview:
- Circular in-order commit buffer between the issue stage and the register file.
- Allocates one entry per issued instruction and returns the entry id as the rename tag. Captures results from the common data bus (CDB).
- Commits the head entry in program order: register writeback, store release, or branch check.
- On a mispredicted branch or jump it issues a one-cycle pipeline flush with a redirect PC. Its commit port drives the register file's writeback/rename-release inputs.

Parameters:
ROB_WIDTH, 4, entry-id width; depth = 2**ROB_WIDTH entries (16).

Ports:
clockIn  input  1  system clock, rising edge
resetIn  input  1  asynchronous, active-low reset
readyIn  input  1  global enable; when 0, all state holds and no commit is emitted
issueValid  input  1  allocate an entry this cycle
issueKind  input  2  0 REG (writes rd), 1 BRANCH, 2 STORE, 3 JUMP (writes rd and checks next PC)
issueRd  input  5  destination register
issuePredPc  input  32  predicted next PC (BRANCH/JUMP)
robFull  output  1  no allocation possible this cycle
robTail  output  ROB_WIDTH  id the next allocation receives
cdbValid  input  1  result broadcast
cdbRobId  input  ROB_WIDTH  target entry
cdbValue  input  32  rd value (REG/JUMP); ignored otherwise
cdbNextPc  input  32  actual next PC (BRANCH/JUMP)
query1Id  input  ROB_WIDTH  operand lookup 1
query1Ready  output  1  entry result available
query1Value  output  32  entry result
query2Id, query2Ready, query2Value  as query 1
writeFlag  output  1  register commit
robId  output  ROB_WIDTH  committing entry id
writeAddr  output  5  committing rd
writeValue  output  32  committing value
storeCommit  output  1  head STORE released to load/store buffer
storeRobId  output  ROB_WIDTH  id of released store
clearOut  output  1  flush pulse
redirectPc  output  32  correct fetch PC, valid while clearOut=1

Behaviour:
- Storage per entry: valid, ready, kind, rd, value, predPc, nextPc. Pointers: head, tail (ROB_WIDTH bits, natural wrap 15 to 0). Count: ROB_WIDTH+1 bits.
- Reset (resetIn=0, asynchronous): head=tail=count=0, all valid=0, state RUN, clearOut=0, redirectPc=0. All commit and query outputs read 0.
- States: RUN and FLUSH.
- RUN, issue:
  - robFull = (count == 2**ROB_WIDTH), evaluated from registered count. Issue while full is ignored, even if a commit occurs in the same cycle.
  - If issueValid & !robFull & readyIn: entry[tail] <= {valid=1, ready=0, kind, rd, predPc}; tail++.
- RUN, CDB: if cdbValid & readyIn & entry[cdbRobId].valid, set ready=1 and store value and nextPc. CDB to an invalid entry is ignored.
- RUN, commit (combinational from head; the entry is freed at the next edge):
  - Commit condition: entry[head].valid & ready & readyIn. The ready bit is the registered bit, so a CDB write to the head lands this cycle and commits next cycle (no same-cycle bypass into commit).
  - REG/JUMP: writeFlag=1, robId=head, writeAddr=rd, writeValue=value. rd=0 is still emitted; the register file drops it.
  - STORE: storeCommit=1, storeRobId=head.
  - BRANCH: no write.
  - On commit: valid[head] <= 0, head++.
  - count <= count + issue − commit; simultaneous issue and commit leaves count unchanged.
- Mispredict: the committing entry is BRANCH or JUMP with nextPc != predPc.
  - That cycle: the normal commit still occurs (JUMP rd write included).
  - Next state FLUSH; redirectPc <= nextPc.
  - Any issue in that same cycle is still accepted; it is discarded by the flush.
- FLUSH:
  - clearOut=1, robFull=1, no commit, issue and CDB ignored.
  - When readyIn=1: clear all valid bits, head=tail=count=0, clearOut <= 0, state RUN.
  - When readyIn=0: FLUSH holds.
- Queries (combinational):
  - queryNReady = valid & (ready | (cdbValid & cdbRobId==queryNId)).
  - queryNValue = cdbValue when the CDB bypass hits, else the stored value.
  - Outputs are 0 for an invalid entry.
- Reset mid-FLUSH or mid-operation: immediate return to the reset state.

Test Plan:
- Issue REG rd=5 (id 0); CDB id0 value 0x1234 → next cycle writeFlag=1, robId=0, writeAddr=5, writeValue=0x1234; count back to 0.
- Issue 16 entries without results → robFull=1, robTail=0. A 17th issue is ignored. Complete id0 → commit; the next issue gets id0 (wrap).
- Issue REG(id0) then STORE(id1); CDB id1 first, then id0 → commits stay in order: writeFlag for id0, then storeCommit with storeRobId=1 the following cycle.
- JUMP rd=1 predPc=0x100; CDB nextPc=0x200, value=0x44 → commit writes x1=0x44. Next cycle clearOut=1, redirectPc=0x200, robFull=1. Then empty with tail=0.
- Query id3 while CDB broadcasts id3 value 7 → query1Ready=1, query1Value=7 in the same cycle.
- readyIn=0 with the head ready → no commit and state frozen. Drive resetIn=0 during FLUSH → clearOut drops immediately and count=0.
